// File: rtl/adc_i_scale_apply.sv
// rtl/adc_i_scale_apply.sv - I-channel ADC gain apply: signed multiply, round, saturate, sync-aligned gain switch
// Scale word is debounced into a candidate and only promoted to the active gain on a frame sync.
module adc_i_scale_apply #(
    parameter int N_SAMP     = 2,
    parameter int SAMPLE_W   = 12,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 12,
    parameter int CNT_W      = 16
) (
    input  logic                       user_clk,
    input  logic                       user_rst_n,
    input  logic [31:0]                scale_word,
    input  logic [N_SAMP*SAMPLE_W-1:0] in_data,
    input  logic                       in_valid,
    input  logic                       in_sync,
    output logic [N_SAMP*OUT_W-1:0]    out_data,
    output logic                       out_valid,
    output logic                       out_sync,
    output logic [17:0]                gain_active,
    output logic                       bypass_active,
    input  logic                       sat_clr,
    output logic [CNT_W-1:0]           sat_count
);
    localparam int PROD_W = SAMPLE_W + 19;
    localparam int SUM_W  = PROD_W + 1;
    localparam int OUT_MAX_I = 2 ** (OUT_W - 1) - 1;
    localparam logic signed [SUM_W-1:0] OUT_MAX  = SUM_W'(OUT_MAX_I);
    localparam logic signed [SUM_W-1:0] OUT_MIN  = SUM_W'(-OUT_MAX_I - 1);
    localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(2 ** (FRAC_SHIFT - 1));
    localparam logic [18:0] UNITY_SCALE = {1'b0, 18'h10000};
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    // {bypass, gain}; scale_word[30:18] carries nothing we use
    logic [18:0] scale_q, scale_d, scale_prev_q, scale_prev_d;
    logic [18:0] cand_q, cand_d, act_q, act_d;
    logic        unused_scale_bits;

    logic [N_SAMP*SAMPLE_W-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
    logic                       s1_valid_q, s1_valid_d, s1_sync_q, s1_sync_d;
    logic                       s2_valid_q, s2_valid_d, s2_sync_q, s2_sync_d;
    logic                       s2_byp_q, s2_byp_d;
    logic signed [PROD_W-1:0]   s2_prod_q [N_SAMP];
    logic signed [PROD_W-1:0]   s2_prod_d [N_SAMP];

    logic [N_SAMP*OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d, out_sync_q, out_sync_d;
    logic [CNT_W-1:0]        sat_count_q, sat_count_d;

    assign unused_scale_bits = ^scale_word[30:18];

    always_comb begin
        scale_d      = {scale_word[31], scale_word[17:0]};
        scale_prev_d = scale_q;
        // two matching consecutive samples reject a word torn by a CDC update
        cand_d       = (scale_q == scale_prev_q) ? scale_q : cand_q;
        act_d        = (in_valid && in_sync) ? cand_q : act_q;
        s1_data_d    = in_data;
        s1_valid_d   = in_valid;
        s1_sync_d    = in_valid && in_sync;
    end

    always_comb begin
        logic signed [SAMPLE_W-1:0] samp;
        logic signed [PROD_W-1:0]   samp_x;
        logic signed [PROD_W-1:0]   gain_x;
        gain_x     = PROD_W'($signed({1'b0, act_q[17:0]}));
        s2_data_d  = s1_data_q;
        s2_valid_d = s1_valid_q;
        s2_sync_d  = s1_sync_q;
        s2_byp_d   = act_q[18];
        for (int k = 0; k < N_SAMP; k++) begin
            samp         = $signed(s1_data_q[k*SAMPLE_W +: SAMPLE_W]);
            samp_x       = PROD_W'(samp);
            s2_prod_d[k] = samp_x * gain_x;
        end
    end

    always_comb begin
        logic signed [SAMPLE_W-1:0] samp;
        logic signed [SUM_W-1:0]    rnd;
        logic signed [OUT_W-1:0]    lane;
        logic [CNT_W:0]             sat_n;
        logic [CNT_W:0]             cnt_sum;
        out_data_d  = out_data_q;
        out_valid_d = s2_valid_q;
        out_sync_d  = s2_valid_q && s2_sync_q;
        sat_n       = '0;
        for (int k = 0; k < N_SAMP; k++) begin
            samp = $signed(s2_data_q[k*SAMPLE_W +: SAMPLE_W]);
            rnd  = SUM_W'(s2_prod_q[k]) + RND_HALF;
            rnd  = rnd >>> FRAC_SHIFT;
            if (s2_byp_q) begin
                lane = OUT_W'(samp);
                lane = lane <<< (OUT_W - SAMPLE_W);
            end else if (rnd > OUT_MAX) begin
                lane  = {1'b0, {(OUT_W-1){1'b1}}};
                sat_n = sat_n + (CNT_W+1)'(1);
            end else if (rnd < OUT_MIN) begin
                lane  = {1'b1, {(OUT_W-1){1'b0}}};
                sat_n = sat_n + (CNT_W+1)'(1);
            end else begin
                lane = rnd[OUT_W-1:0];
            end
            if (s2_valid_q) out_data_d[k*OUT_W +: OUT_W] = lane;
        end
        cnt_sum = {1'b0, sat_count_q} + (s2_valid_q ? sat_n : '0);
        if (sat_clr)                sat_count_d = '0;
        else if (cnt_sum > CNT_MAX) sat_count_d = '1;
        else                        sat_count_d = cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            scale_q      <= UNITY_SCALE;
            scale_prev_q <= UNITY_SCALE;
            cand_q       <= UNITY_SCALE;
            act_q        <= UNITY_SCALE;
            s1_data_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_sync_q    <= 1'b0;
            s2_data_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_sync_q    <= 1'b0;
            s2_byp_q     <= 1'b0;
            for (int k = 0; k < N_SAMP; k++) s2_prod_q[k] <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_sync_q   <= 1'b0;
            sat_count_q  <= '0;
        end else begin
            scale_q      <= scale_d;
            scale_prev_q <= scale_prev_d;
            cand_q       <= cand_d;
            act_q        <= act_d;
            s1_data_q    <= s1_data_d;
            s1_valid_q   <= s1_valid_d;
            s1_sync_q    <= s1_sync_d;
            s2_data_q    <= s2_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_sync_q    <= s2_sync_d;
            s2_byp_q     <= s2_byp_d;
            for (int k = 0; k < N_SAMP; k++) s2_prod_q[k] <= s2_prod_d[k];
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_sync_q   <= out_sync_d;
            sat_count_q  <= sat_count_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign out_sync      = out_sync_q;
    assign gain_active   = act_q[17:0];
    assign bypass_active = act_q[18];
    assign sat_count     = sat_count_q;
endmodule
